// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter (processor A, debug host B): round-robin on ties, hold-limited ownership.
// Grant registered one edge after request; RAM strobes combinational from owner; non-owner waits on o_gnt, ack one cycle after strobe.
module dm_arbiter #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 16,
  parameter int MAX_HOLD    = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_req_a,
  input  logic                   i_req_b,
  input  logic                   i_wr_a,
  input  logic                   i_wr_b,
  input  logic                   i_rd_a,
  input  logic                   i_rd_b,
  input  logic [ADDR_LENGTH-1:0] i_addr_a,
  input  logic [ADDR_LENGTH-1:0] i_addr_b,
  input  logic [DATA_LENGTH-1:0] i_data_a,
  input  logic [DATA_LENGTH-1:0] i_data_b,
  output logic                   o_gnt_a,
  output logic                   o_gnt_b,
  output logic                   o_ack_a,
  output logic                   o_ack_b,
  output logic [DATA_LENGTH-1:0] o_data_a,
  output logic [DATA_LENGTH-1:0] o_data_b,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic [DATA_LENGTH-1:0] o_Data,
  output logic                   o_Wr,
  output logic                   o_Rd,
  input  logic [DATA_LENGTH-1:0] i_Data
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic       last_b, last_b_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       own_a, own_b, hold_done;

  assign own_a     = (state == OWN_A);
  assign own_b     = (state == OWN_B);
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign o_gnt_a   = own_a;
  assign o_gnt_b   = own_b;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_b   <= last_b_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Release hands straight over to a waiting port so there is no idle bubble.
  always_comb begin
    state_nxt    = state;
    last_b_nxt   = last_b;
    hold_cnt_nxt = hold_cnt;
    unique case (state)
      IDLE: begin
        if (i_req_a && (!i_req_b || last_b)) state_nxt = OWN_A;
        else if (i_req_b)                    state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!i_req_a || (hold_done && i_req_b)) state_nxt = i_req_b ? OWN_B : IDLE;
      end
      OWN_B: begin
        if (!i_req_b || (hold_done && i_req_a)) state_nxt = i_req_a ? OWN_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE) begin
      hold_cnt_nxt = '0;
    end else if (state_nxt != state) begin
      last_b_nxt   = (state_nxt == OWN_B);
      hold_cnt_nxt = '0;
    end else if (!hold_done) begin
      hold_cnt_nxt = hold_cnt + 8'd1;
    end
  end

  // Write wins when an owner raises both strobes.
  always_comb begin
    o_Addr = '0;
    o_Data = '0;
    o_Wr   = 1'b0;
    o_Rd   = 1'b0;
    if (own_a) begin
      o_Addr = i_addr_a;
      o_Data = i_data_a;
      o_Wr   = i_wr_a;
      o_Rd   = i_rd_a & ~i_wr_a;
    end else if (own_b) begin
      o_Addr = i_addr_b;
      o_Data = i_data_b;
      o_Wr   = i_wr_b;
      o_Rd   = i_rd_b & ~i_wr_b;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ack_a  <= 1'b0;
      o_ack_b  <= 1'b0;
      o_data_a <= '0;
      o_data_b <= '0;
    end else begin
      o_ack_a <= own_a & (i_wr_a | i_rd_a);
      o_ack_b <= own_b & (i_wr_b | i_rd_b);
      if (own_a && i_rd_a && !i_wr_a) o_data_a <= i_Data;
      if (own_b && i_rd_b && !i_wr_b) o_data_b <= i_Data;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand sequences for hold/reset corners, random run vs. reference model.
`timescale 1ns/1ps
module tb_dm_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int MH = 8;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_req_a, i_req_b, i_wr_a, i_wr_b, i_rd_a, i_rd_b;
  logic [AW-1:0] i_addr_a, i_addr_b;
  logic [DW-1:0] i_data_a, i_data_b;
  logic          o_gnt_a, o_gnt_b, o_ack_a, o_ack_b, o_Wr, o_Rd;
  logic [DW-1:0] o_data_a, o_data_b, o_Data, i_Data;
  logic [AW-1:0] o_Addr;

  dm_arbiter #(.ADDR_LENGTH(AW), .DATA_LENGTH(DW), .MAX_HOLD(MH)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_wr_a(i_wr_a), .i_wr_b(i_wr_b), .i_rd_a(i_rd_a), .i_rd_b(i_rd_b),
    .i_addr_a(i_addr_a), .i_addr_b(i_addr_b), .i_data_a(i_data_a), .i_data_b(i_data_b),
    .o_gnt_a(o_gnt_a), .o_gnt_b(o_gnt_b), .o_ack_a(o_ack_a), .o_ack_b(o_ack_b),
    .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_Addr(o_Addr), .o_Data(o_Data), .o_Wr(o_Wr), .o_Rd(o_Rd), .i_Data(i_Data)
  );

  always #5 i_clock = ~i_clock;

  // Stand-in for dm_ram: asynchronous read, synchronous write.
  logic [DW-1:0] ram [0:2047];
  logic          ram_clr = 1'b1;
  assign i_Data = ram[o_Addr];
  always @(posedge i_clock) begin
    if (ram_clr) for (int i = 0; i < 2048; i++) ram[i] <= DW'(i * 7);
    else if (o_Wr) ram[o_Addr] <= o_Data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: owner 0=none 1=A 2=B, held = owned cycles completed.
  int            m_own, m_last, m_held;
  logic          m_ack_a, m_ack_b;
  logic [DW-1:0] m_dat_a, m_dat_b;
  logic [DW-1:0] ref_mem [0:2047];

  task automatic model_reset();
    m_own = 0; m_last = 2; m_held = 0;
    m_ack_a = 1'b0; m_ack_b = 1'b0; m_dat_a = '0; m_dat_b = '0;
  endtask

  task automatic model_edge();
    logic mine, other;
    m_ack_a = (m_own == 1) && (i_wr_a || i_rd_a);
    m_ack_b = (m_own == 2) && (i_wr_b || i_rd_b);
    if (m_own == 1) begin
      if (i_wr_a) ref_mem[i_addr_a] = i_data_a;
      else if (i_rd_a) m_dat_a = ref_mem[i_addr_a];
    end else if (m_own == 2) begin
      if (i_wr_b) ref_mem[i_addr_b] = i_data_b;
      else if (i_rd_b) m_dat_b = ref_mem[i_addr_b];
    end
    if (m_own == 0) begin
      if (i_req_a && i_req_b) m_own = (m_last == 1) ? 2 : 1;
      else if (i_req_a) m_own = 1;
      else if (i_req_b) m_own = 2;
      if (m_own != 0) begin m_last = m_own; m_held = 0; end
    end else begin
      mine  = (m_own == 1) ? i_req_a : i_req_b;
      other = (m_own == 1) ? i_req_b : i_req_a;
      m_held++;
      if (!mine || (m_held >= MH && other)) begin
        if (other) begin m_own = 3 - m_own; m_last = m_own; m_held = 0; end
        else m_own = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_wr, e_rd;
    e_addr = '0; e_data = '0; e_wr = 1'b0; e_rd = 1'b0;
    if (m_own == 1) begin
      e_addr = i_addr_a; e_data = i_data_a; e_wr = i_wr_a; e_rd = i_rd_a && !i_wr_a;
    end else if (m_own == 2) begin
      e_addr = i_addr_b; e_data = i_data_b; e_wr = i_wr_b; e_rd = i_rd_b && !i_wr_b;
    end
    chk("m_gnt_a", o_gnt_a, m_own == 1);
    chk("m_gnt_b", o_gnt_b, m_own == 2);
    chk("m_ack_a", o_ack_a, m_ack_a);
    chk("m_ack_b", o_ack_b, m_ack_b);
    chk("m_data_a", o_data_a, m_dat_a);
    chk("m_data_b", o_data_b, m_dat_b);
    chk("m_Addr", o_Addr, e_addr);
    chk("m_Data", o_Data, e_data);
    chk("m_Wr", o_Wr, e_wr);
    chk("m_Rd", o_Rd, e_rd);
  endtask

  task automatic cycle();
    @(posedge i_clock);
    #1;
    model_edge();
    check_all();
  endtask

  typedef struct {
    logic ra, rb, wa, rda, wb, rdb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    logic ga, gb, ka, kb, wr, rd;
    logic [DW-1:0] xdb;
  } vec_t;

  vec_t tv [12];

  task automatic drive(input vec_t v);
    i_req_a = v.ra; i_req_b = v.rb; i_wr_a = v.wa; i_rd_a = v.rda;
    i_wr_b = v.wb; i_rd_b = v.rdb; i_addr_a = v.aa; i_addr_b = v.ab;
    i_data_a = v.da; i_data_b = v.db;
  endtask

  initial begin
    int cnt_a, gap, got_b;
    // ra rb wa rda wb rdb aa ab da db | gnt_a gnt_b ack_a ack_b Wr Rd data_b
    tv[0]  = '{1,1,0,0,0,0, 11'h000, 11'h000, 16'h0000, 16'h0000, 1,0,0,0,0,0, 16'h0000};
    tv[1]  = '{1,1,1,0,0,0, 11'h010, 11'h000, 16'hBEEF, 16'h0000, 1,0,1,0,1,0, 16'h0000};
    tv[2]  = '{0,1,0,0,0,0, 11'h000, 11'h000, 16'h0000, 16'h0000, 0,1,0,0,0,0, 16'h0000};
    tv[3]  = '{0,1,0,0,0,1, 11'h000, 11'h010, 16'h0000, 16'h0000, 0,1,0,1,0,1, 16'hBEEF};
    tv[4]  = '{1,0,0,0,0,0, 11'h000, 11'h000, 16'h0000, 16'h0000, 1,0,0,0,0,0, 16'hBEEF};
    tv[5]  = '{1,0,1,0,1,0, 11'h020, 11'h030, 16'h1111, 16'h2222, 1,0,1,0,1,0, 16'hBEEF};
    tv[6]  = '{1,0,1,1,0,0, 11'h040, 11'h000, 16'h1234, 16'h0000, 1,0,1,0,1,0, 16'hBEEF};
    tv[7]  = '{0,0,0,0,0,0, 11'h000, 11'h000, 16'h0000, 16'h0000, 0,0,0,0,0,0, 16'hBEEF};
    tv[8]  = '{1,1,0,0,0,1, 11'h000, 11'h040, 16'h0000, 16'h0000, 0,1,0,0,0,1, 16'hBEEF};
    tv[9]  = '{1,1,0,0,0,1, 11'h000, 11'h040, 16'h0000, 16'h0000, 0,1,0,1,0,1, 16'h1234};
    tv[10] = '{1,1,0,0,0,1, 11'h000, 11'h030, 16'h0000, 16'h0000, 0,1,0,1,0,1, 16'h0150};
    tv[11] = '{0,0,0,0,0,0, 11'h000, 11'h000, 16'h0000, 16'h0000, 0,0,0,0,0,0, 16'h0150};

    for (int i = 0; i < 2048; i++) ref_mem[i] = DW'(i * 7);
    drive(tv[11]);
    repeat (3) @(posedge i_clock);
    #1;
    model_reset();
    check_all();
    ram_clr = 1'b0;
    #2 i_reset = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i]);
      cycle();
      chk($sformatf("v%0d_gnt_a", i), o_gnt_a, tv[i].ga);
      chk($sformatf("v%0d_gnt_b", i), o_gnt_b, tv[i].gb);
      chk($sformatf("v%0d_ack_a", i), o_ack_a, tv[i].ka);
      chk($sformatf("v%0d_ack_b", i), o_ack_b, tv[i].kb);
      chk($sformatf("v%0d_Wr", i), o_Wr, tv[i].wr);
      chk($sformatf("v%0d_Rd", i), o_Rd, tv[i].rd);
      chk($sformatf("v%0d_data_b", i), o_data_b, tv[i].xdb);
    end

    // Hold limit: A streams writes with B waiting.
    i_req_a = 1; i_req_b = 1; i_wr_a = 1; i_addr_a = 11'h100; i_data_a = 16'hA5A5;
    cnt_a = 0; gap = 0; got_b = 0;
    for (int c = 0; c < 40 && !got_b; c++) begin
      cycle();
      if (o_gnt_b) got_b = 1;
      else if (o_gnt_a) cnt_a++;
      else if (cnt_a > 0) gap = 1;
    end
    chk("v2_got_b", got_b, 1);
    chk("v2_own_cycles", cnt_a, MH);
    chk("v2_no_gap", gap, 0);

    // Asynchronous reset in the middle of a B read.
    i_req_a = 0; i_wr_a = 0; i_rd_b = 1; i_addr_b = 11'h010;
    cycle();
    chk("v6_pre_rd", o_Rd, 1);
    #2 i_reset = 1'b0;
    #1;
    chk("v6_gnt_b", o_gnt_b, 0);
    chk("v6_rd", o_Rd, 0);
    chk("v6_ack_b", o_ack_b, 0);
    chk("v6_data_b", o_data_b, 0);
    model_reset();
    check_all();
    #2 i_reset = 1'b1;
    i_req_b = 0; i_rd_b = 0; i_req_a = 1;
    cycle();
    chk("v6_gnt_a", o_gnt_a, 1);

    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(7) == 0) i_req_a = ~i_req_a;
      if ($urandom_range(7) == 0) i_req_b = ~i_req_b;
      i_wr_a = ($urandom_range(3) == 0); i_rd_a = ($urandom_range(2) == 0);
      i_wr_b = ($urandom_range(3) == 0); i_rd_b = ($urandom_range(2) == 0);
      i_addr_a = AW'($urandom_range(15)); i_addr_b = AW'($urandom_range(15));
      i_data_a = DW'($urandom); i_data_b = DW'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_LENGTH  11  data-memory address width
  DATA_LENGTH  16  data-memory word width
  MAX_HOLD     8   max consecutive owned cycles while the other port waits; legal range 2..255
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  i_clock          in   1            single clock, rising edge
  i_reset          in   1            asynchronous, active-low reset
  i_req_a/i_req_b  in   1            port A (processor) / port B (debug host) request ownership
  i_wr_a/i_wr_b    in   1            write strobe, valid while granted
  i_rd_a/i_rd_b    in   1            read strobe, valid while granted
  i_addr_a/i_addr_b  in   ADDR_LENGTH  access address
  i_data_a/i_data_b  in   DATA_LENGTH  write data
  o_gnt_a/o_gnt_b  out  1            registered grant, one-hot or zero
  o_ack_a/o_ack_b  out  1            registered 1-cycle access acknowledge
  o_data_a/o_data_b  out  DATA_LENGTH  registered read data
  o_Addr           out  ADDR_LENGTH  to dm_ram i_Addr
  o_Data           out  DATA_LENGTH  to dm_ram i_Data
  o_Wr / o_Rd      out  1            to dm_ram Wr / Rd
  i_Data           in   DATA_LENGTH  from dm_ram o_Data

Function
REQ-003 FSM SHALL have exactly three states: IDLE, OWN_A, OWN_B; o_gnt_a = (state==OWN_A), o_gnt_b = (state==OWN_B), both from registers.
REQ-004 IDLE: only one request -> go to that port's OWN state; both -> go to the port opposite the last-owner pointer; none -> stay in IDLE.
REQ-005 Last-owner pointer SHALL update to the port entered on every transition into an OWN state.
REQ-006 Grant latency: request sampled high at edge k in IDLE -> gnt high from edge k.
REQ-007 Hold counter SHALL clear on entering an OWN state, increment each owned cycle, saturate at MAX_HOLD-1.
REQ-008 OWN_X SHALL be released at the edge where i_req_x is low, or where counter==MAX_HOLD-1 and the other request is high.
REQ-009 On release, if the other request is high, next state SHALL be the other OWN state directly (no IDLE bubble); otherwise IDLE.
REQ-010 When the other request is low, the owner SHALL keep ownership indefinitely with the counter saturated.
REQ-011 o_Addr/o_Data/o_Wr/o_Rd SHALL be combinational from the current owner's inputs; in IDLE all SHALL be 0.
REQ-012 Owner strobe with both wr and rd high: write SHALL win; o_Rd=0.
REQ-013 Strobes from the non-owner port SHALL be ignored: no RAM strobe, no ack.
REQ-014 Owner strobe sampled at edge m SHALL produce o_ack_x high for exactly the cycle after edge m; for reads, o_data_x SHALL capture i_Data at edge m and hold until the next read ack of that port.
REQ-015 A strobe at the release edge SHALL still be performed and acknowledged.
REQ-016 Request dropped while strobe high: access performed and acked, ownership released at the same edge.

Reset
REQ-017 i_reset low SHALL asynchronously force: state IDLE, pointer = B (so A wins the first tie), counter 0, all gnt/ack 0, o_data_a/o_data_b 0.
REQ-018 Reset asserted mid-access SHALL abort the access without ack; RAM strobes SHALL drop to 0 immediately.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
  V1 both req high together from reset -> o_gnt_a first; pointer flips; B granted after A releases.
  V2 A owns, B req held, A streams writes every cycle, MAX_HOLD=8 -> A owns exactly 8 cycles; o_gnt_b high on the next cycle, no IDLE gap.
  V3 A writes 16'hBEEF @ 11'h010, releases; B reads @ 11'h010 -> o_ack_b pulses 1 cycle, o_data_b = 16'hBEEF.
  V4 B strobes wr while A owns -> o_Wr follows A only; no o_ack_b; RAM contents at B's address unchanged.
  V5 owner asserts wr and rd together, data 16'h1234 -> o_Wr=1, o_Rd=0; write lands; one ack.
  V6 i_reset low mid-read in OWN_B -> o_gnt_b, o_Rd, o_ack_b all 0 without waiting for a clock edge; after release, idle A req -> grant A.
